fetch_queue_unit: RTL and testbench

//  Parametrised instruction-fetch front end for the pipelined core. Replaces the

---
 rtl/fetch_queue_if.sv | 36 +++
 rtl/fetch_queue_unit.sv | 86 ++++++++
 tb/tb_fetch_queue_unit.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_if.sv
// Fetch front-end bundle: imem request/response, redirect, and the decode-side handshake.
interface fetch_queue_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 3
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_rdata;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_instr;
  logic [ADDR_W-1:0] out_pc;
  logic [ADDR_W-1:0] out_pcplus4;
  logic [CNT_W-1:0]  count;

  modport master (
    output imem_req, imem_addr,
    input  imem_rdata,
    input  redirect, redirect_pc,
    output out_valid,
    input  out_ready,
    output out_instr, out_pc, out_pcplus4, count
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_rdata,
    output redirect, redirect_pc,
    input  out_valid,
    output out_ready,
    input  out_instr, out_pc, out_pcplus4, count
  );
endinterface

// File: rtl/fetch_queue_unit.sv
// Decoupled fetch PC plus DEPTH-entry prefetch queue; request->out_valid 2 cycles, redirect->valid 3 cycles.
// Backpressure: requests stop once queued + in-flight fills DEPTH; a same-cycle pop does not free a slot.
module fetch_queue_unit #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          reset,
  fetch_queue_if.master bus
);
  localparam int                PTR_W   = $clog2(DEPTH);
  localparam int                CNT_W   = PTR_W + 1;
  localparam logic [CNT_W:0]    DEPTH_C = (CNT_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] WORD    = ADDR_W'(4);

  typedef struct packed {
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] pc;
  } entry_t;

  entry_t            mem [DEPTH];
  logic [ADDR_W-1:0] fpc;
  logic [ADDR_W-1:0] inflight_pc;
  logic              inflight;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W:0]    occupancy;
  logic              req;
  logic              push;
  logic              pop;
  logic              unused_pc_bits;

  assign unused_pc_bits = ^bus.redirect_pc[1:0];

  // Slots already promised to the in-flight fetch count as occupied.
  assign occupancy = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight};
  assign req       = !reset && !bus.redirect && (occupancy < DEPTH_C);
  assign push      = inflight && !bus.redirect;
  assign pop       = bus.out_valid && bus.out_ready;

  assign bus.imem_req    = req;
  assign bus.imem_addr   = fpc;
  assign bus.out_valid   = !reset && (count_q != '0);
  assign bus.out_instr   = mem[rd_ptr].instr;
  assign bus.out_pc      = mem[rd_ptr].pc;
  assign bus.out_pcplus4 = mem[rd_ptr].pc + WORD;
  assign bus.count       = count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      fpc         <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count_q     <= '0;
    end else if (bus.redirect) begin
      // The response to last cycle's request is dropped by clearing inflight.
      fpc      <= {bus.redirect_pc[ADDR_W-1:2], 2'b00};
      inflight <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count_q  <= '0;
    end else begin
      inflight <= req;
      if (req) begin
        fpc         <= fpc + WORD;
        inflight_pc <= fpc;
      end
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !reset) mem[wr_ptr] <= '{instr: bus.imem_rdata, pc: inflight_pc};
  end
endmodule

// File: tb/tb_fetch_queue_unit.sv
// Random redirect/reset/backpressure against a queue-based model, on a DEPTH=4 unit and a wrapping DEPTH=2 unit.
module tb_fetch_queue_unit;
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

  logic        clk;
  logic        rst   [2];
  logic        redir [2];
  logic [31:0] rpc   [2];
  logic        rdy   [2];

  logic        obs_req   [2];
  logic [31:0] obs_addr  [2];
  logic        obs_valid [2];
  logic [31:0] obs_instr [2];
  logic [31:0] obs_pc    [2];
  logic [31:0] obs_pc4   [2];
  logic [31:0] obs_cnt   [2];

  entry_t      mq [2][$];
  bit          m_inf   [2];
  logic [31:0] m_ipc   [2];
  logic [31:0] m_fpc   [2];
  int          m_depth [2] = '{4, 2};
  logic [31:0] m_rstpc [2] = '{32'h0, 32'hFFFF_FFF8};
  int          mode    [2];

  int n_chk  = 0;
  int n_pass = 0;

  fetch_queue_if #(.ADDR_W(32), .DATA_W(32), .CNT_W(3)) bus0();
  fetch_queue_if #(.ADDR_W(32), .DATA_W(32), .CNT_W(2)) bus1();

  fetch_queue_unit #(.ADDR_W(32), .DATA_W(32), .DEPTH(4), .RESET_PC(32'h0)) dut0 (
    .clk(clk), .reset(rst[0]), .bus(bus0)
  );
  fetch_queue_unit #(.ADDR_W(32), .DATA_W(32), .DEPTH(2), .RESET_PC(32'hFFFF_FFF8)) dut1 (
    .clk(clk), .reset(rst[1]), .bus(bus1)
  );

  function automatic logic [31:0] imem_f(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  assign bus0.redirect    = redir[0];
  assign bus0.redirect_pc = rpc[0];
  assign bus0.out_ready   = rdy[0];
  assign bus1.redirect    = redir[1];
  assign bus1.redirect_pc = rpc[1];
  assign bus1.out_ready   = rdy[1];

  assign obs_req[0]   = bus0.imem_req;
  assign obs_addr[0]  = bus0.imem_addr;
  assign obs_valid[0] = bus0.out_valid;
  assign obs_instr[0] = bus0.out_instr;
  assign obs_pc[0]    = bus0.out_pc;
  assign obs_pc4[0]   = bus0.out_pcplus4;
  assign obs_cnt[0]   = {29'b0, bus0.count};
  assign obs_req[1]   = bus1.imem_req;
  assign obs_addr[1]  = bus1.imem_addr;
  assign obs_valid[1] = bus1.out_valid;
  assign obs_instr[1] = bus1.out_instr;
  assign obs_pc[1]    = bus1.out_pc;
  assign obs_pc4[1]   = bus1.out_pcplus4;
  assign obs_cnt[1]   = {30'b0, bus1.count};

  // 1-cycle imem; garbage on idle cycles so a stray write would show.
  always @(posedge clk) begin
    bus0.imem_rdata <= bus0.imem_req ? imem_f(bus0.imem_addr) : $urandom;
    bus1.imem_rdata <= bus1.imem_req ? imem_f(bus1.imem_addr) : $urandom;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic bit model_req(input int k);
    return !rst[k] && !redir[k] && ((mq[k].size() + int'(m_inf[k])) < m_depth[k]);
  endfunction

  task automatic pick_inputs(input int k, input int cyc);
    int sel;
    if (cyc < 3) begin
      rst[k] = 1'b1; redir[k] = 1'b0; rdy[k] = 1'b1; rpc[k] = 32'h0;
    end else if (cyc < 40) begin
      rst[k] = 1'b0; redir[k] = 1'b0; rdy[k] = 1'b1;
    end else begin
      if (cyc % 40 == 0) mode[k] = $urandom_range(0, 3);
      rst[k]   = ($urandom_range(0, 199) == 0);
      redir[k] = ($urandom_range(0, 99) < ((mode[k] == 3) ? 20 : 4));
      case (mode[k])
        0:       rdy[k] = 1'b1;
        1:       rdy[k] = ($urandom_range(0, 9) == 0);
        2:       rdy[k] = 1'($urandom_range(0, 1));
        default: rdy[k] = ($urandom_range(0, 3) != 0);
      endcase
      sel = $urandom_range(0, 3);
      case (sel)
        0:       rpc[k] = $urandom;
        1:       rpc[k] = 32'h101;
        2:       rpc[k] = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        default: rpc[k] = 32'($urandom_range(0, 255));
      endcase
    end
  endtask

  task automatic check_outputs(input int k);
    bit er;
    bit ev;
    er = model_req(k);
    ev = !rst[k] && (mq[k].size() != 0);
    check_val($sformatf("u%0d.imem_req", k), {31'b0, obs_req[k]}, {31'b0, er});
    if (er) check_val($sformatf("u%0d.imem_addr", k), obs_addr[k], m_fpc[k]);
    check_val($sformatf("u%0d.out_valid", k), {31'b0, obs_valid[k]}, {31'b0, ev});
    check_val($sformatf("u%0d.count", k), obs_cnt[k], 32'(mq[k].size()));
    if (ev) begin
      check_val($sformatf("u%0d.out_instr", k), obs_instr[k], mq[k][0].instr);
      check_val($sformatf("u%0d.out_pc", k), obs_pc[k], mq[k][0].pc);
      check_val($sformatf("u%0d.out_pcplus4", k), obs_pc4[k], mq[k][0].pc + 32'd4);
    end
  endtask

  // What the posedge must do, given the inputs now applied.
  task automatic model_step(input int k);
    bit er;
    er = model_req(k);
    if (rst[k]) begin
      mq[k].delete();
      m_inf[k] = 1'b0;
      m_fpc[k] = m_rstpc[k];
    end else if (redir[k]) begin
      mq[k].delete();
      m_inf[k] = 1'b0;
      m_fpc[k] = rpc[k] & 32'hFFFF_FFFC;
    end else begin
      if (mq[k].size() != 0 && rdy[k]) void'(mq[k].pop_front());
      if (m_inf[k]) mq[k].push_back('{instr: imem_f(m_ipc[k]), pc: m_ipc[k]});
      m_inf[k] = er;
      if (er) begin
        m_ipc[k] = m_fpc[k];
        m_fpc[k] = m_fpc[k] + 32'd4;
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1; redir[k] = 1'b0; rdy[k] = 1'b0; rpc[k] = 32'h0; mode[k] = 0;
      m_inf[k] = 1'b0; m_ipc[k] = 32'h0; m_fpc[k] = m_rstpc[k];
    end
    @(posedge clk);
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) pick_inputs(k, cyc);
      #1;
      for (int k = 0; k < 2; k++) begin
        check_outputs(k);
        model_step(k);
      end
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
